// File: rtl/fetch_stage_ctrl_if.sv
// Hazard-unit / ID-side handshake bundle for the fetch stage: control in, PC and IF/ID latch out.
// The slave modport is the fetch stage itself; the master side drives control and observes outputs.
interface fetch_stage_ctrl_if;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_flush;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic [1:0]  FetchState;
  logic        StallTimeout;
  logic [31:0] StallCount;
  logic [31:0] FlushCount;

  modport master (
    output PCWrite, IF_ID_Write, IF_ID_flush, Redirect, RedirectTarget, Instruction,
    input  PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, FetchState,
           StallTimeout, StallCount, FlushCount
  );

  modport slave (
    input  PCWrite, IF_ID_Write, IF_ID_flush, Redirect, RedirectTarget, Instruction,
    output PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, FetchState,
           StallTimeout, StallCount, FlushCount
  );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage control: PC register, IF/ID latch, RUN/STALL/FLUSH tracking and a sticky stall watchdog.
// Latency: one edge for every output. Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 16
) (
  input logic             Clk,
  input logic             Rst,
  fetch_stage_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [7:0] STALL_LIMIT = 8'(MAX_STALL);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instr_q, ifid_pcp4_q;
  logic        ifid_valid_q;
  logic [7:0]  stall_run_q, stall_run_d;
  logic        timeout_q;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state depends only on this cycle's hazard inputs, so encoding 3 can never persist.
  always_comb begin
    state_d     = ST_RUN;
    stall_run_d = 8'd0;
    pc_d        = pc_q;
    if (bus.IF_ID_flush) begin
      state_d = ST_FLUSH;
    end else if (!bus.PCWrite) begin
      state_d = ST_STALL;
    end
    if (state_d == ST_STALL) begin
      stall_run_d = (stall_run_q == 8'hFF) ? 8'hFF : stall_run_q + 8'd1;
    end
    if (bus.PCWrite) begin
      pc_d = bus.Redirect ? {bus.RedirectTarget[31:2], 2'b00} : pc_plus4;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= 32'h0;
      ifid_pcp4_q  <= 32'h0;
      ifid_valid_q <= 1'b0;
      stall_run_q  <= 8'd0;
      timeout_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      stall_run_q <= stall_run_d;
      if (stall_run_d >= STALL_LIMIT) begin
        timeout_q <= 1'b1;
      end
      if (bus.IF_ID_flush) begin
        ifid_instr_q <= 32'h0;
        ifid_pcp4_q  <= 32'h0;
        ifid_valid_q <= 1'b0;
      end else if (bus.IF_ID_Write) begin
        ifid_instr_q <= bus.Instruction;
        ifid_pcp4_q  <= pc_plus4;
        ifid_valid_q <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_total_q, flush_total_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_total_q <= 32'h0;
      flush_total_q <= 32'h0;
    end else begin
      if (!bus.PCWrite) begin
        stall_total_q <= stall_total_q + 32'd1;
      end
      if (bus.IF_ID_flush) begin
        flush_total_q <= flush_total_q + 32'd1;
      end
    end
  end

  assign bus.StallCount = stall_total_q;
  assign bus.FlushCount = flush_total_q;
`else
  assign bus.StallCount = 32'h0;
  assign bus.FlushCount = 32'h0;
`endif

  assign bus.PC                = pc_q;
  assign bus.IF_ID_Instruction = ifid_instr_q;
  assign bus.IF_ID_PCPlus4     = ifid_pcp4_q;
  assign bus.IF_ID_Valid       = ifid_valid_q;
  assign bus.FetchState        = state_q;
  assign bus.StallTimeout      = timeout_q;

endmodule

// File: doc/fetch_stage_ctrl.md
# fetch_stage_ctrl

- Owns the PC register and the IF/ID pipeline register.
- Executes the PCWrite / IF_ID_Write / IF_ID_flush decisions issued each cycle by the hazard detection unit.
- Applies taken branch/jump/jr redirects from ID.
- Tracks fetch-stall status with a consecutive-stall watchdog.
- Sits between instruction memory and the ID stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_STALL, 16, consecutive stalled cycles that trip the watchdog (1..255).

Ports:
- Clk  input  1  rising-edge clock; one clock domain.
- Rst  input  1  asynchronous, active-low reset.
- PCWrite  input  1  1 = PC may advance this cycle; 0 = hold PC.
- IF_ID_Write  input  1  1 = load IF/ID from fetch; 0 = hold IF/ID.
- IF_ID_flush  input  1  1 = load a bubble into IF/ID (overrides IF_ID_Write).
- Redirect  input  1  taken branch/jump/jr this cycle.
- RedirectTarget  input  32  next-PC for a redirect.
- Instruction  input  32  instruction-memory read data for the current PC.
- PC  output  32  current fetch address, registered.
- IF_ID_Instruction  output  32  latched instruction; 32'h0 (nop) for a bubble.
- IF_ID_PCPlus4  output  32  latched PC+4; 0 for a bubble.
- IF_ID_Valid  output  1  1 = IF/ID holds a real instruction.
- FetchState  output  2  0 RUN, 1 STALL, 2 FLUSH.
- StallTimeout  output  1  sticky watchdog flag.
- StallCount  output  32  total stalled cycles (see Configuration).
- FlushCount  output  32  total flush cycles (see Configuration).

## Operation
PC update, evaluated at each rising Clk:
- PCWrite=0: PC holds. Redirect is ignored.
- PCWrite=1 and Redirect=1: PC <= {RedirectTarget[31:2], 2'b00}.
- PCWrite=1 and Redirect=0: PC <= PC+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.

IF/ID update, first matching rule wins:
- IF_ID_flush=1: Instruction <= 0, PCPlus4 <= 0, Valid <= 0.
- IF_ID_Write=1: Instruction <= Instruction input, PCPlus4 <= PC+4 (pre-update PC), Valid <= 1.
- Otherwise: all IF/ID fields hold.

FSM:
- Next state is decoded from the current inputs with priority flush > stall > run:
  - IF_ID_flush=1 -> FLUSH.
  - else PCWrite=0 -> STALL.
  - else RUN.
- Every state can reach every other state. There are no illegal encodings; encoding 3 recovers to RUN.

Stall watchdog:
- An 8-bit consecutive-stall counter increments in each cycle whose next state is STALL, saturating at 255.
- It clears to 0 in any cycle whose next state is not STALL.
- When the counter reaches MAX_STALL, StallTimeout sets and stays at 1 until reset.

Simultaneous events:
- Flush together with PCWrite=0: IF/ID is bubbled, PC holds, state is FLUSH, and the stall counter clears.
- Flush together with IF_ID_Write=1: flush wins.

## Timing
- All outputs are registered; every input is sampled on the rising Clk.
- PC drives instruction memory combinationally. Instruction for PC N appears in IF_ID_Instruction one edge after a fetch with IF_ID_Write=1.
- Redirect latency: one edge. The PC equals the target in the cycle after Redirect & PCWrite.
- Reset: asynchronous assert on Rst=0, synchronous-safe release. While Rst=0, all of the following hold:
  - PC=RESET_PC.
  - IF_ID_Instruction=0, IF_ID_PCPlus4=0, IF_ID_Valid=0.
  - FetchState=RUN.
  - StallTimeout=0.
  - StallCount=0, FlushCount=0.
  - Stall counter=0.
- Reset asserted mid-stall or mid-flush: the state is discarded immediately. The first edge after release fetches from RESET_PC.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - StallCount increments in each cycle with PCWrite=0.
  - FlushCount increments in each cycle with IF_ID_flush=1.
  - Both counters are 32-bit, wrap modulo 2^32, and update on the same edge as the event.
- FETCH_PERF_CNT_EN undefined:
  - Both counters are not instantiated.
  - StallCount and FlushCount are tied to 32'h0.
  - All other behaviour is identical.

## Test plan
1. Reset check: RESET_PC=32'h100. Hold Rst=0 for 3 cycles, then release with PCWrite=IF_ID_Write=1 and Instruction=32'h2008_0005. Required: PC sequence 0x100 -> 0x104 -> 0x108. IF_ID_Instruction=32'h2008_0005 with IF_ID_PCPlus4=0x104 after the first edge; Valid=1.
2. Stall: PC=0x200, PCWrite=IF_ID_Write=0 for 2 cycles. Required: PC stays 0x200, IF/ID is unchanged, FetchState=STALL, and StallCount rises by 2 (with FETCH_PERF_CNT_EN).
3. Redirect with flush: PC=0x300, PCWrite=1, Redirect=1, RedirectTarget=32'h0000_0407, IF_ID_flush=1. Required: next PC=0x404, IF_ID_Valid=0, IF_ID_Instruction=0, FetchState=FLUSH, FlushCount+1.
4. Wrap-around: PC=32'hFFFF_FFFC, PCWrite=1, Redirect=0. Required: next PC=0. IF_ID_PCPlus4=0 when IF_ID_Write=1.
5. Watchdog: MAX_STALL=4. Apply PCWrite=0 for 3 cycles, one RUN cycle, then PCWrite=0 for 4 cycles. Required: StallTimeout stays 0 through the first burst and is 1 after the 4th cycle of the second burst. It stays 1 through later RUN cycles until Rst=0.
6. Async reset mid-stall: assert Rst=0 midway between edges during a STALL at PC=0x500. Required: PC=RESET_PC and IF_ID_Valid=0 before the next Clk edge; StallTimeout=0.
